// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the game-logic / video timing slice.
//   - VGA 640x480 geometry constants, used as parameter defaults elsewhere.
//   - COUNT_W: width of the row/column counters from the sync/count stage.
//   - sched_state_t: state encoding of the vertical-blank update scheduler.
//   - at_line_start(): true on the first pixel (col 0) of a given row.
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int VGA_TOTAL_COLS  = 800;
   localparam int VGA_TOTAL_ROWS  = 525;
   localparam int VGA_ACTIVE_ROWS = 480;

   // Both counters share one width; 800 columns need 10 bits.
   localparam int COUNT_W = $clog2(VGA_TOTAL_COLS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GRANT = 2'd2
   } sched_state_t;

   // First column of the requested row.
   function automatic logic at_line_start(
      input logic [COUNT_W-1:0] row,
      input logic [COUNT_W-1:0] col,
      input logic [COUNT_W-1:0] target_row
   );
      return (row == target_row) && (col == '0);
   endfunction

endpackage

// File: rtl/vblank_update_scheduler_slot_timer.sv
// -----------------------------------------------------------------------------
// slot_timer
//   Counts the cycles a single grant has been held.
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous reset, active low (count -> 0)
//     load     in   restart the count at 0 (wins over enable)
//     enable   in   advance the count by one this cycle
//     terminal out  count has reached MAX_SLOT_CYCLES-1
// -----------------------------------------------------------------------------
module slot_timer #(
   parameter int MAX_SLOT_CYCLES = 4096,
   parameter int CNT_W           = $clog2(MAX_SLOT_CYCLES)
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic terminal
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_SLOT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (enable) begin
         // Never runs past LAST_COUNT in practice: the owner leaves GRANT
         // on the terminal cycle, so wrap-around is harmless.
         count_reg <= count_reg + 1'b1;
      end
   end

   assign terminal = (count_reg == LAST_COUNT);

endmodule

// File: rtl/vblank_update_scheduler.sv
// -----------------------------------------------------------------------------
// vblank_update_scheduler
//   Confines game-logic updates (ship, meteors, bullets, score) to the
//   vertical blanking interval. A window opens on the first blanking row,
//   requesters are offered exclusive access one at a time in ascending
//   index order, each grant is bounded by a slot timeout, and the window is
//   forcibly closed a little before the next frame's active video.
//
//   Ports:
//     i_Clk          in   pixel clock
//     i_Rst_L        in   asynchronous reset, active low
//     i_Col_Count    in   column counter from the sync/count stage
//     i_Row_Count    in   row counter from the sync/count stage
//     i_Req          in   level, requester n has an update pending
//     i_Done         in   pulse, requester n finished its update
//     o_Grant        out  one-hot (or zero) exclusive update permission
//     o_Frame_Tick   out  one-cycle pulse when the window opens
//     o_Frame_Count  out  frames since reset (wraps)
//     o_Busy         out  scheduler is inside an update window
//     o_Timeout_Err  out  one-cycle pulse when a grant is revoked by timeout
//     o_Overrun      out  one-cycle pulse when the window is force-closed
//                         while still busy
// -----------------------------------------------------------------------------
module vblank_update_scheduler
   import game_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
   parameter int WIN_END_ROW     = VGA_TOTAL_ROWS - 2,
   parameter int MAX_SLOT_CYCLES = 4096
)(
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic [COUNT_W-1:0] i_Col_Count,
   input  logic [COUNT_W-1:0] i_Row_Count,
   input  logic [NUM_REQ-1:0] i_Req,
   input  logic [NUM_REQ-1:0] i_Done,
   output logic [NUM_REQ-1:0] o_Grant,
   output logic               o_Frame_Tick,
   output logic [15:0]        o_Frame_Count,
   output logic               o_Busy,
   output logic               o_Timeout_Err,
   output logic               o_Overrun
);

   // idx must be able to hold NUM_REQ itself: that value marks "all scanned".
   localparam int IDX_W = $clog2(NUM_REQ + 1);

   localparam logic [COUNT_W-1:0] OPEN_ROW  = COUNT_W'(ACTIVE_ROWS);
   localparam logic [COUNT_W-1:0] CLOSE_ROW = COUNT_W'(WIN_END_ROW);
   localparam logic [IDX_W-1:0]   IDX_END   = IDX_W'(NUM_REQ);

   sched_state_t       state_reg,     state_next;
   logic [IDX_W-1:0]   idx_reg,       idx_next;
   logic [NUM_REQ-1:0] grant_reg,     grant_next;
   logic [15:0]        frame_cnt_reg, frame_cnt_next;
   logic               tick_reg,      tick_next;
   logic               timeout_reg,   timeout_next;
   logic               overrun_reg,   overrun_next;
   logic               busy_reg;

   logic               open_hit;
   logic               close_hit;
   logic [NUM_REQ-1:0] idx_onehot;
   logic [NUM_REQ-1:0] req_hit;
   logic [NUM_REQ-1:0] done_hit;
   logic               req_sel;
   logic               done_sel;
   logic               timer_load;
   logic               timer_enable;
   logic               timer_tc;

   // ------------------------------------------------------------------
   // Window boundaries, detected on the first column of the row
   // ------------------------------------------------------------------
   assign open_hit  = at_line_start(i_Row_Count, i_Col_Count, OPEN_ROW);
   assign close_hit = at_line_start(i_Row_Count, i_Col_Count, CLOSE_ROW);

   // ------------------------------------------------------------------
   // Per-requester decode. Indexing through a compare (rather than
   // i_Req[idx_reg]) keeps idx == NUM_REQ from reading out of range.
   // A done pulse only counts for the index that currently holds the
   // grant; stray pulses from anyone else fall out here.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
      assign req_hit[gi]    = i_Req[gi] & idx_onehot[gi];
      assign done_hit[gi]   = i_Done[gi] & grant_reg[gi];
   end

   assign req_sel  = |req_hit;
   assign done_sel = |done_hit;

   // ------------------------------------------------------------------
   // Slot timer: restarted as a grant is issued, runs while granting
   // ------------------------------------------------------------------
   assign timer_enable = (state_reg == GRANT);

   slot_timer #(
      .MAX_SLOT_CYCLES (MAX_SLOT_CYCLES)
   ) u_slot_timer (
      .clk      (i_Clk),
      .rst_n    (i_Rst_L),
      .load     (timer_load),
      .enable   (timer_enable),
      .terminal (timer_tc)
   );

   // ------------------------------------------------------------------
   // Scheduler next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      grant_next     = grant_reg;
      frame_cnt_next = frame_cnt_reg;
      tick_next      = 1'b0;
      timeout_next   = 1'b0;
      overrun_next   = 1'b0;
      timer_load     = 1'b0;

      if ((state_reg != IDLE) && close_hit) begin
         // Forced close outranks done, timeout and scan advance so that
         // nothing is still being written when active video resumes.
         state_next   = IDLE;
         grant_next   = '0;
         overrun_next = 1'b1;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (open_hit) begin
                  state_next     = SCAN;
                  idx_next       = '0;
                  tick_next      = 1'b1;
                  frame_cnt_next = frame_cnt_reg + 16'd1;
               end
            end

            SCAN: begin
               if (idx_reg == IDX_END) begin
                  state_next = IDLE;
               end else if (req_sel) begin
                  state_next = GRANT;
                  grant_next = idx_onehot;
                  timer_load = 1'b1;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end

            GRANT: begin
               // Done on the terminal cycle still counts as a clean finish.
               if (done_sel) begin
                  state_next = SCAN;
                  grant_next = '0;
                  idx_next   = idx_reg + 1'b1;
               end else if (timer_tc) begin
                  state_next   = SCAN;
                  grant_next   = '0;
                  idx_next     = idx_reg + 1'b1;
                  timeout_next = 1'b1;
               end
            end

            default: begin
               state_next = IDLE;
               grant_next = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         grant_reg     <= '0;
         frame_cnt_reg <= '0;
         tick_reg      <= 1'b0;
         timeout_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         grant_reg     <= grant_next;
         frame_cnt_reg <= frame_cnt_next;
         tick_reg      <= tick_next;
         timeout_reg   <= timeout_next;
         overrun_reg   <= overrun_next;
         busy_reg      <= (state_next != IDLE);
      end
   end

   assign o_Grant       = grant_reg;
   assign o_Frame_Tick  = tick_reg;
   assign o_Frame_Count = frame_cnt_reg;
   assign o_Busy        = busy_reg;
   assign o_Timeout_Err = timeout_reg;
   assign o_Overrun     = overrun_reg;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vblank_update_scheduler
//   Two schedulers share one 10x8 raster (window opens at row 4, closes at
//   row 7): unit 0 has a 5-cycle slot limit, unit 1 a 4096-cycle one.
//   For every frame the bench lays out the expected timeline directly from
//   the scheduling rules (scan cycle per index, grant length from the done
//   delay or the slot limit, forced close) and compares it cycle by cycle.
// -----------------------------------------------------------------------------
module tb_vblank_update_scheduler;

   localparam int NF       = 80;   // cycles per frame (10 cols x 8 rows)
   localparam int OPEN_F   = 41;   // first cycle after (row4,col0)
   localparam int CLOSE_F  = 70;   // cycle presenting (row7,col0)

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] col, row;
   logic [3:0] req_a, done_a, req_b, done_b;
   logic [3:0] grant_a, grant_b;
   logic       tick_a, tick_b, busy_a, busy_b, to_a, to_b, ov_a, ov_b;
   logic [15:0] fc_a, fc_b;

   int checks = 0;
   int errors = 0;

   logic [3:0]  s_req   [2][NF];
   logic [3:0]  s_done  [2][NF];
   logic [3:0]  e_grant [2][NF];
   logic        e_busy  [2][NF];
   logic        e_to    [2][NF];
   logic        e_ov    [2][NF];
   logic [23:0] e_vec   [2][NF];
   logic [23:0] o_vec   [2][NF];
   logic [15:0] frame_base [2];

   always #5 clk = ~clk;

   vblank_update_scheduler #(
      .NUM_REQ(4), .ACTIVE_ROWS(4), .WIN_END_ROW(7), .MAX_SLOT_CYCLES(5)
   ) dut_a (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row),
      .i_Req(req_a), .i_Done(done_a), .o_Grant(grant_a), .o_Frame_Tick(tick_a),
      .o_Frame_Count(fc_a), .o_Busy(busy_a), .o_Timeout_Err(to_a), .o_Overrun(ov_a)
   );

   vblank_update_scheduler #(
      .NUM_REQ(4), .ACTIVE_ROWS(4), .WIN_END_ROW(7), .MAX_SLOT_CYCLES(4096)
   ) dut_b (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row),
      .i_Req(req_b), .i_Done(done_b), .o_Grant(grant_b), .o_Frame_Tick(tick_b),
      .o_Frame_Count(fc_b), .o_Busy(busy_b), .o_Timeout_Err(to_b), .o_Overrun(ov_b)
   );

   // Done delay in cycles after the grant rises, or -1 for "never".
   function automatic int rk(input int hi);
      if ($urandom_range(0, 3) == 0) return -1;
      return int'($urandom_range(32'(hi), 0));
   endfunction

   // Expected timeline for one frame of unit u. k* = done delay per index.
   task automatic build(input int u, input logic [3:0] ra,
                        input int k0, input int k1, input int k2, input int k3,
                        input int maxc, input logic [3:0] drop, input bit junk);
      int ks [4];
      int p, g, len, c;
      bit tmo;
      logic [15:0] fc;
      ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
      for (int f = 0; f < NF; f++) begin
         s_req[u][f] = ra; s_done[u][f] = '0; e_grant[u][f] = '0;
         e_busy[u][f] = 1'b0; e_to[u][f] = 1'b0; e_ov[u][f] = 1'b0;
      end
      p = OPEN_F;   // cycle in which index i is examined
      for (int i = 0; i < 4; i++) begin
         if (ra[i]) begin
            g   = p + 1;
            tmo = !(ks[i] >= 0 && ks[i] < maxc);
            len = tmo ? maxc : ks[i] + 1;
            for (c = g; c < g + len && c < NF; c++) e_grant[u][c][i] = 1'b1;
            if (ks[i] >= 0 && g + ks[i] < NF) s_done[u][g + ks[i]][i] = 1'b1;
            if (drop[i]) for (c = g + 1; c < NF; c++) s_req[u][c][i] = 1'b0;
            if (tmo && g + len < NF) e_to[u][g + len] = 1'b1;
            p = g + len;
         end else begin
            p = p + 1;
         end
      end
      // p is the cycle examining index 4; idle afterwards.
      for (c = OPEN_F; c <= p && c < NF; c++) e_busy[u][c] = 1'b1;
      if (p >= CLOSE_F) begin
         for (c = CLOSE_F + 1; c < NF; c++) begin
            e_grant[u][c] = '0; e_busy[u][c] = 1'b0; e_to[u][c] = 1'b0;
         end
         e_ov[u][CLOSE_F + 1] = 1'b1;
      end
      if (junk) begin
         for (int j = 0; j < 4; j++) begin
            c = int'($urandom_range(NF - 1, 0));
            if (!e_grant[u][c][j]) s_done[u][c][j] = 1'b1;
         end
      end
      for (int f = 0; f < NF; f++) begin
         fc = frame_base[u] + ((f >= OPEN_F) ? 16'd1 : 16'd0);
         e_vec[u][f] = {fc, e_ov[u][f], e_to[u][f], 1'(f == OPEN_F),
                        e_busy[u][f], e_grant[u][f]};
      end
   endtask

   // Drive one frame (cycles 0..last); record the outputs seen in each cycle.
   task automatic play_frame(input int last);
      for (int f = 0; f <= last; f++) begin
         @(negedge clk);
         o_vec[0][f] = {fc_a, ov_a, to_a, tick_a, busy_a, grant_a};
         o_vec[1][f] = {fc_b, ov_b, to_b, tick_b, busy_b, grant_b};
         row    = 10'(f / 10);
         col    = 10'(f % 10);
         req_a  = s_req[0][f];  done_a = s_done[0][f];
         req_b  = s_req[1][f];  done_b = s_done[1][f];
      end
   endtask

   task automatic build_partner_b();
      build(1, 4'($urandom), rk(12), rk(12), rk(12), rk(12), 4096, 4'($urandom), 1'b1);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({fc_a, ov_a, to_a, tick_a, busy_a, grant_a} !== 24'd0) begin
         errors++; $display("FAIL reset_hold_a got %h exp 000000", {fc_a, ov_a, to_a, tick_a, busy_a, grant_a});
      end
      checks++;
      if ({fc_b, ov_b, to_b, tick_b, busy_b, grant_b} !== 24'd0) begin
         errors++; $display("FAIL reset_hold_b got %h exp 000000", {fc_b, ov_b, to_b, tick_b, busy_b, grant_b});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({fc_a, busy_a, grant_a, fc_b, busy_b, grant_b} !== 42'd0) begin
         errors++; $display("FAIL reset_release got fc=%h/%h busy=%b/%b exp 0", fc_a, fc_b, busy_a, busy_b);
      end
      $display("test_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_all_req();
      logic [15:0] seq;
      logic [3:0]  prev;
      build(0, 4'b1111, 3, 3, 3, 3, 5, 4'b0000, 1'b0);
      build_partner_b();
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL all_req u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      seq = '0; prev = '0;
      for (int f = 0; f < NF; f++) begin
         if (o_vec[0][f][3:0] != 4'd0 && o_vec[0][f][3:0] != prev) seq = {seq[11:0], o_vec[0][f][3:0]};
         prev = o_vec[0][f][3:0];
      end
      checks++;
      if (seq !== 16'h1248) begin
         errors++; $display("FAIL all_req_order got %h exp 1248", seq);
      end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_all_req done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_sparse();
      logic [7:0] seq;
      logic [3:0] prev;
      build(0, 4'b1010, 0, int'($urandom_range(3, 0)), 0, int'($urandom_range(3, 0)), 5, 4'b0000, 1'b0);
      build_partner_b();
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL sparse u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      checks++;
      if (o_vec[0][43][3:0] !== 4'b0010) begin
         errors++; $display("FAIL sparse_first_grant got %b exp 0010", o_vec[0][43][3:0]);
      end
      seq = '0; prev = '0;
      for (int f = 0; f < NF; f++) begin
         if (o_vec[0][f][3:0] != 4'd0 && o_vec[0][f][3:0] != prev) seq = {seq[3:0], o_vec[0][f][3:0]};
         prev = o_vec[0][f][3:0];
      end
      checks++;
      if (seq !== 8'h28) begin
         errors++; $display("FAIL sparse_order got %h exp 28", seq);
      end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_sparse done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_timeout();
      int held, pulses;
      build(0, 4'b0011, -1, 2, 0, 0, 5, 4'b0000, 1'b0);
      build_partner_b();
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL timeout u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      held = 0; pulses = 0;
      for (int f = 0; f < NF; f++) begin
         if (o_vec[0][f][0]) held++;
         if (o_vec[0][f][6]) pulses++;
      end
      checks++;
      if (held != 5) begin
         errors++; $display("FAIL timeout_hold got %0d cycles exp 5", held);
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses);
      end
      checks++;
      if (o_vec[0][48][3:0] !== 4'b0010) begin
         errors++; $display("FAIL timeout_next_grant got %b exp 0010", o_vec[0][48][3:0]);
      end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_timeout done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_overrun();
      build(0, 4'($urandom), rk(7), rk(7), rk(7), rk(7), 5, 4'($urandom), 1'b1);
      build(1, 4'b0100, -1, -1, -1, -1, 4096, 4'b0100, 1'b0);
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL overrun u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      checks++;
      if (o_vec[1][CLOSE_F][3:0] !== 4'b0100) begin
         errors++; $display("FAIL overrun_held got %b exp 0100", o_vec[1][CLOSE_F][3:0]);
      end
      checks++;
      if (o_vec[1][CLOSE_F + 1][7:0] !== 8'b1000_0000) begin
         errors++; $display("FAIL overrun_close got %b exp 10000000", o_vec[1][CLOSE_F + 1][7:0]);
      end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_overrun done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_ignore_done();
      build(0, 4'b0001, -1, 0, 0, 0, 5, 4'b0001, 1'b0);
      build(1, 4'b0011, 6, 2, 0, 0, 4096, 4'b0000, 1'b0);
      // Stray done pulses: on a non-granted index during a grant, and
      // on every index before the window opens.
      s_done[0][44] = 4'b1110;
      s_done[1][44] = 4'b0010;
      s_done[1][10] = 4'b1111;
      s_done[0][10] = 4'b1111;
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL ignore_done u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      checks++;
      if (o_vec[1][45][3:0] !== 4'b0001) begin
         errors++; $display("FAIL ignore_done_grant got %b exp 0001", o_vec[1][45][3:0]);
      end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_ignore_done done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_grant();
      build(0, 4'b0001, -1, 0, 0, 0, 5, 4'b0000, 1'b0);
      build(1, 4'b0001, -1, 0, 0, 0, 4096, 4'b0000, 1'b0);
      play_frame(43);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f <= 43; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL mid_reset_pre u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({grant_a, grant_b, busy_a, busy_b, fc_a, fc_b} !== 42'd0) begin
         errors++; $display("FAIL mid_reset_async got grant=%b/%b busy=%b/%b fc=%h/%h exp 0",
                            grant_a, grant_b, busy_a, busy_b, fc_a, fc_b);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      frame_base[0] = '0; frame_base[1] = '0;
      @(negedge clk);
      checks++;
      if ({grant_a, grant_b, busy_a, busy_b, fc_a, fc_b} !== 42'd0) begin
         errors++; $display("FAIL mid_reset_release got grant=%b/%b busy=%b/%b fc=%h/%h exp 0",
                            grant_a, grant_b, busy_a, busy_b, fc_a, fc_b);
      end
      // Next window must start from index 0 with a fresh frame count.
      build(0, 4'b1001, 1, 0, 0, 2, 5, 4'b0000, 1'b0);
      build(1, 4'b0001, 0, 0, 0, 0, 4096, 4'b0000, 1'b0);
      play_frame(NF - 1);
      for (int u = 0; u < 2; u++)
         for (int f = 0; f < NF; f++) begin
            checks++;
            if (o_vec[u][f] !== e_vec[u][f]) begin
               errors++; $display("FAIL mid_reset_post u%0d f%0d got %h exp %h", u, f, o_vec[u][f], e_vec[u][f]);
            end
         end
      frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      $display("test_reset_mid_grant done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         build(0, 4'($urandom), rk(7), rk(7), rk(7), rk(7), 5, 4'($urandom), 1'b1);
         build_partner_b();
         play_frame(NF - 1);
         for (int u = 0; u < 2; u++)
            for (int f = 0; f < NF; f++) begin
               checks++;
               if (o_vec[u][f] !== e_vec[u][f]) begin
                  errors++; $display("FAIL random n%0d u%0d f%0d got %h exp %h", n, u, f, o_vec[u][f], e_vec[u][f]);
               end
            end
         frame_base[0] += 16'd1; frame_base[1] += 16'd1;
      end
      $display("test_random done checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      col = '0; row = '0;
      req_a = '0; done_a = '0; req_b = '0; done_b = '0;
      frame_base[0] = '0; frame_base[1] = '0;
      test_reset();
      test_all_req();
      test_sparse();
      test_timeout();
      test_overrun();
      test_ignore_done();
      test_reset_mid_grant();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
